frb_trigger: RTL and testbench

Threshold detector that sits directly downstream of the dedispersor's per-frame power integrator. It consumes one integrated power value per frame (`integ_pow`/`integ_valid`) and tracks a running-mean baseline over the last 2^AVG_LEN_LOG2 frames. It raises a one-cycle trigger with captured power and frame number when a frame exceeds baseline + threshold, then holds off re-triggering for a programmable number of frames.

---
 rtl/frb_trig_pkg.sv | 21 ++
 rtl/frb_baseline_avg.sv | 46 ++++
 rtl/frb_trigger.sv | 97 +++++++++
 tb/tb_frb_trigger.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/frb_trig_pkg.sv
// Shared types and default widths for the FRB threshold trigger.
// Optional build macro: FRB_TRIG_BASELINE_FREEZE_EN (keeps bursts out of the baseline).
package frb_trig_pkg;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOLDOFF = 2'd2
  } trig_state_e;

  localparam int DEF_DIN_WIDTH    = 32;
  localparam int DEF_AVG_LEN_LOG2 = 4;
  localparam int DEF_HOLDOFF      = 64;
  localparam int DEF_CNT_WIDTH    = 32;
  localparam int DEF_SUM_WIDTH    = DEF_DIN_WIDTH + DEF_AVG_LEN_LOG2;

  function automatic int sum_width(input int din_w, input int avg_log2);
    return din_w + avg_log2;
  endfunction

endpackage

// File: rtl/frb_baseline_avg.sv
// Running-mean baseline over the last 2^AVG_LEN_LOG2 written frames.
// Circular window, running sum, truncated mean and a sticky fill flag.
module frb_baseline_avg
  import frb_trig_pkg::*;
#(
  parameter int DIN_WIDTH    = DEF_DIN_WIDTH,
  parameter int AVG_LEN_LOG2 = DEF_AVG_LEN_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [DIN_WIDTH-1:0] din,
  output logic [DIN_WIDTH-1:0] baseline,
  output logic                 filled,
  output logic                 fill_last
);

  localparam int DEPTH = 1 << AVG_LEN_LOG2;
  localparam int SW    = sum_width(DIN_WIDTH, AVG_LEN_LOG2);

  logic [DEPTH-1:0][DIN_WIDTH-1:0] win_q;
  logic [AVG_LEN_LOG2-1:0]         wr_ptr;
  logic [AVG_LEN_LOG2:0]           fill_cnt;
  logic [SW-1:0]                   sum;

  // Combinational so the FSM can arm on the same edge that writes the last fill frame.
  assign fill_last = we && !filled && (fill_cnt == (AVG_LEN_LOG2+1)'(DEPTH - 1));
  assign baseline  = sum[SW-1:AVG_LEN_LOG2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q    <= '0;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      sum      <= '0;
      filled   <= 1'b0;
    end else if (we) begin
      sum           <= sum + SW'(din) - SW'(win_q[wr_ptr]);
      win_q[wr_ptr] <= din;
      wr_ptr        <= wr_ptr + 1'b1;
      if (!filled) fill_cnt <= fill_cnt + 1'b1;
      if (fill_last) filled <= 1'b1;
    end
  end

endmodule

// File: rtl/frb_trigger.sv
// Per-frame threshold trigger: fires when power exceeds baseline + thresh, then holds off.
// Optional build macro: FRB_TRIG_BASELINE_FREEZE_EN (trigger/holdoff frames not averaged).
module frb_trigger
  import frb_trig_pkg::*;
#(
  parameter int DIN_WIDTH    = DEF_DIN_WIDTH,
  parameter int AVG_LEN_LOG2 = DEF_AVG_LEN_LOG2,
  parameter int HOLDOFF      = DEF_HOLDOFF,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [DIN_WIDTH-1:0] integ_pow,
  input  logic                 integ_valid,
  input  logic [DIN_WIDTH-1:0] thresh,
  output logic [DIN_WIDTH-1:0] baseline,
  output logic                 baseline_valid,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic                 trig,
  output logic [DIN_WIDTH-1:0] trig_pow,
  output logic [CNT_WIDTH-1:0] trig_frame
);

  localparam int HCW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  trig_state_e    state_q, state_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic           frame_vld, hit, fire, we, fill_last;

  assign frame_vld = ce && integ_valid;
  // One extra bit on the right-hand side so baseline + thresh never wraps.
  assign hit = {1'b0, integ_pow} > ({1'b0, baseline} + {1'b0, thresh});

`ifdef FRB_TRIG_BASELINE_FREEZE_EN
  assign we = frame_vld && !fire && (state_q != ST_HOLDOFF);
`else
  assign we = frame_vld;
`endif

  frb_baseline_avg #(
    .DIN_WIDTH    (DIN_WIDTH),
    .AVG_LEN_LOG2 (AVG_LEN_LOG2)
  ) u_avg (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .din       (integ_pow),
    .baseline  (baseline),
    .filled    (baseline_valid),
    .fill_last (fill_last)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    fire    = 1'b0;
    if (frame_vld) begin
      case (state_q)
        ST_FILL: if (fill_last) state_d = ST_ARMED;
        ST_ARMED: begin
          if (hit) begin
            fire   = 1'b1;
            hold_d = HCW'(HOLDOFF);
            if (HOLDOFF != 0) state_d = ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          hold_d = hold_q - 1'b1;
          if (hold_q == HCW'(1)) state_d = ST_ARMED;
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_FILL;
      hold_q     <= '0;
      trig       <= 1'b0;
      trig_pow   <= '0;
      trig_frame <= '0;
      frame_cnt  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      trig    <= fire;
      if (fire) begin
        trig_pow   <= integ_pow;
        trig_frame <= frame_cnt;
      end
      if (frame_vld) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_frb_trigger.sv
// Directed + randomized bench for frb_trigger against a frame-level reference model.
module tb_frb_trigger;

  localparam int  DW   = 32;
  localparam int  CW   = 32;
  localparam int  WIN  = 16;
  localparam int  HOLD = 64;
`ifdef FRB_TRIG_BASELINE_FREEZE_EN
  localparam bit  FREEZE = 1'b1;
`else
  localparam bit  FREEZE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ce = 1'b0;
  logic [DW-1:0] integ_pow = '0;
  logic          integ_valid = 1'b0;
  logic [DW-1:0] thresh = '0;
  logic [DW-1:0] baseline;
  logic          baseline_valid;
  logic [CW-1:0] frame_cnt;
  logic          trig;
  logic [DW-1:0] trig_pow;
  logic [CW-1:0] trig_frame;

  frb_trigger dut (
    .clk            (clk),
    .rst            (rst),
    .ce             (ce),
    .integ_pow      (integ_pow),
    .integ_valid    (integ_valid),
    .thresh         (thresh),
    .baseline       (baseline),
    .baseline_valid (baseline_valid),
    .frame_cnt      (frame_cnt),
    .trig           (trig),
    .trig_pow       (trig_pow),
    .trig_frame     (trig_frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: window of the last WIN averaged frames, mode as 0=fill 1=armed 2=holdoff.
  longint unsigned win[$];
  int              m_mode, m_fills, m_hold;
  bit              m_trig, m_bv;
  logic [DW-1:0]   m_tp;
  logic [CW-1:0]   m_tf, m_fcnt;

  function automatic longint unsigned m_base();
    longint unsigned s = 0;
    foreach (win[i]) s += win[i];
    return s / WIN;
  endfunction

  task automatic m_reset();
    win.delete();
    m_mode = 0; m_fills = 0; m_hold = 0;
    m_trig = 0; m_bv = 0; m_tp = '0; m_tf = '0; m_fcnt = '0;
  endtask

  task automatic m_frame(input longint unsigned p, input longint unsigned th);
    longint unsigned b = m_base();
    bit hit = (p > b + th);
    bit wr = 1'b1;
    m_trig = 1'b0;
    if (m_mode == 0) begin
      m_fills++;
      if (m_fills == WIN) begin m_bv = 1'b1; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (hit) begin
        m_trig = 1'b1; m_tp = p[DW-1:0]; m_tf = m_fcnt; m_hold = HOLD;
        if (HOLD > 0) m_mode = 2;
        if (FREEZE) wr = 1'b0;
      end
    end else begin
      m_hold--;
      if (m_hold == 0) m_mode = 1;
      if (FREEZE) wr = 1'b0;
    end
    if (wr) begin
      win.push_back(p);
      if (win.size() > WIN) void'(win.pop_front());
    end
    m_fcnt++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".trig"},       64'(trig),           64'(m_trig));
    chk({tag, ".trig_pow"},   64'(trig_pow),       64'(m_tp));
    chk({tag, ".trig_frame"}, 64'(trig_frame),     64'(m_tf));
    chk({tag, ".baseline"},   64'(baseline),       m_base());
    chk({tag, ".bvalid"},     64'(baseline_valid), 64'(m_bv));
    chk({tag, ".frame_cnt"},  64'(frame_cnt),      64'(m_fcnt));
  endtask

  task automatic frame(input logic [DW-1:0] p, input logic [DW-1:0] th);
    @(negedge clk);
    ce = 1'b1; integ_valid = 1'b1; integ_pow = p; thresh = th;
    @(posedge clk); #1;
    integ_valid = 1'b0;
    m_frame(p, th);
    check_all("frm");
  endtask

  // Non-frame cycle: either ce low with a (ignored) strobe, or ce high with no strobe.
  task automatic idle(input int n, input bit ce_low);
    repeat (n) begin
      @(negedge clk);
      ce = !ce_low; integ_valid = ce_low; integ_pow = $urandom;
      @(posedge clk); #1;
      m_trig = 1'b0;
      check_all(ce_low ? "ce0" : "idle");
    end
    ce = 1'b1; integ_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    m_reset();
    check_all("rst");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    m_reset();
    #2;
    check_all("por");
    ce = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // Fill with 100s.
    repeat (WIN) frame(100, 50);
    chk("fill.bvalid", 64'(baseline_valid), 64'd1);
    chk("fill.base",   64'(baseline), 64'd100);
    chk("fill.cnt",    64'(frame_cnt), 64'd16);

    // 150 is not above 150; it is then averaged in (baseline 103) and 160 clears 153.
    frame(150, 50);
    chk("f150.trig", 64'(trig), 64'd0);
    frame(160, 50);
    chk("f160.trig",  64'(trig), 64'd1);
    chk("f160.pow",   64'(trig_pow), 64'd160);
    chk("f160.frame", 64'(trig_frame), 64'd17);
    idle(1, 1'b0);
    chk("pulse.trig", 64'(trig), 64'd0);

    // Holdoff of 64 frames, then the 65th large frame.
    repeat (HOLD) frame(1000, 50);
    frame(1000, 50);
    chk("h65.trig", 64'(trig), FREEZE ? 64'd1 : 64'd0);

    // ce low ignores strobes.
    idle(10, 1'b1);
    chk("ce0.cnt", 64'(frame_cnt), 64'd83);

    // Reach holdoff in either build, then reset mid-holdoff.
    frame(5000, 50);
    do_reset();
    chk("rst.trig", 64'(trig), 64'd0);
    repeat (WIN - 1) frame(100, 50);
    chk("refill15.bvalid", 64'(baseline_valid), 64'd0);
    frame(100, 50);
    chk("refill16.bvalid", 64'(baseline_valid), 64'd1);

    // Top-of-range comparison must not wrap.
    do_reset();
    repeat (WIN) frame(32'hFFFF_FFF0, 32'h20);
    frame(32'hFFFF_FFFF, 32'h20);
    chk("ovf.thr20", 64'(trig), 64'd0);
    frame(32'hFFFF_FFFF, 32'h0);
    chk("ovf.thr0", 64'(trig), 64'd1);

    // Randomized traffic with gaps, ce drops and occasional bursts.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int r = $urandom_range(0, 9);
      if (r < 2) idle($urandom_range(1, 3), 1'($urandom_range(0, 1)));
      else if (r == 2) frame(DW'($urandom_range(200, 600)), DW'($urandom_range(0, 60)));
      else frame(DW'($urandom_range(90, 110)), DW'($urandom_range(0, 60)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
